// File: rtl/text_term_writer.sv
// text_term_writer
//   Byte-stream front end for the text-display character RAM (ram_sync).
//   Printable bytes are written at the cursor. CR, LF, BS and FF move the cursor.
//   A line feed or wrap past the bottom row scrolls the screen up one row by
//   copying the RAM in place. The whole screen is cleared to spaces after reset
//   and on FF. This block is the only writer of the RAM.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   in_data     character byte
//   in_valid    in_data valid
//   in_ready    byte taken on an edge with in_valid && in_ready
//   ram_addr    RAM address (row*COLS + col)
//   ram_din     RAM write data
//   ram_we      RAM write enable
//   ram_dout    RAM read data, one cycle after ram_addr
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//   busy        high whenever no byte can be accepted
//
// Timing model: st_q names the action taken at the next edge. RAM strobes are
// registered, so each action shows up on the RAM port in the cycle after its edge.
module text_term_writer #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 30,
    parameter int unsigned D    = 10,
    parameter int unsigned W    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [D-1:0]            ram_addr,
    output logic [W-1:0]            ram_din,
    output logic                    ram_we,
    input  logic [W-1:0]            ram_dout,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);
    localparam logic [D-1:0]  IDX_END    = D'(COLS * ROWS - 1);
    localparam logic [D-1:0]  IDX_CPY    = D'(COLS * (ROWS - 1) - 1);
    localparam logic [D-1:0]  IDX_BOTTOM = D'(COLS * (ROWS - 1));
    localparam logic [W-1:0]  SPACE      = W'(8'h20);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StWrite,
        StScrollRd,
        StScrollWr,
        StScrollClr
    } state_e;

    state_e          st_q, st_d;
    logic [D-1:0]    idx_q, idx_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            we_q, we_d;
    logic [D-1:0]    addr_q, addr_d;
    logic [W-1:0]    din_q, din_d;
    logic            ready_q, ready_d;
    // Set for the cycle a scroll copy write is on the port; din then comes from the RAM.
    logic            pass_q, pass_d;

    logic [D-1:0]    cur_addr;
    logic            accept;
    logic            printable;

    assign cur_addr  = D'(int'(row_q) * COLS + int'(col_q));
    assign accept    = in_valid && ready_q && (st_q == StIdle);
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        ready_d = 1'b0;
        pass_d  = 1'b0;

        case (st_q)
            StClear: begin
                we_d   = 1'b1;
                addr_d = idx_q;
                din_d  = SPACE;
                if (idx_q == IDX_END) begin
                    st_d  = StIdle;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + D'(1);
                end
            end

            StIdle: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (printable) begin
                        st_d    = StWrite;
                        we_d    = 1'b1;
                        addr_d  = cur_addr;
                        din_d   = W'(in_data);
                        ready_d = 1'b0;
                    end else begin
                        case (in_data)
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d = col_q - CW'(1);
                                end
                            end
                            8'h0A: begin
                                if (row_q < ROW_MAX) begin
                                    row_d = row_q + RW'(1);
                                end else begin
                                    // First copy read goes out now; row stays at the bottom.
                                    st_d    = StScrollWr;
                                    idx_d   = '0;
                                    addr_d  = D'(COLS);
                                    ready_d = 1'b0;
                                end
                            end
                            8'h0C: begin
                                // Issue the first clear write here so the clear takes
                                // exactly COLS*ROWS cycles.
                                col_d   = '0;
                                row_d   = '0;
                                st_d    = StClear;
                                idx_d   = D'(1);
                                we_d    = 1'b1;
                                addr_d  = '0;
                                din_d   = SPACE;
                                ready_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            StWrite: begin
                if (col_q < COL_MAX) begin
                    col_d   = col_q + CW'(1);
                    st_d    = StIdle;
                    ready_d = 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q < ROW_MAX) begin
                        row_d   = row_q + RW'(1);
                        st_d    = StIdle;
                        ready_d = 1'b1;
                    end else begin
                        st_d   = StScrollWr;
                        idx_d  = '0;
                        addr_d = D'(COLS);
                    end
                end
            end

            StScrollRd: begin
                addr_d = D'(int'(idx_q) + COLS);
                st_d   = StScrollWr;
            end

            StScrollWr: begin
                we_d   = 1'b1;
                addr_d = idx_q;
                pass_d = 1'b1;
                if (idx_q == IDX_CPY) begin
                    st_d  = StScrollClr;
                    idx_d = IDX_BOTTOM;
                end else begin
                    st_d  = StScrollRd;
                    idx_d = idx_q + D'(1);
                end
            end

            StScrollClr: begin
                we_d   = 1'b1;
                addr_d = idx_q;
                din_d  = SPACE;
                if (idx_q == IDX_END) begin
                    st_d  = StIdle;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + D'(1);
                end
            end

            default: begin
                st_d  = StClear;
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q    <= StClear;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            pass_q  <= pass_d;
        end
    end

    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_din    = pass_q ? ram_dout : din_q;
    assign in_ready   = ready_q;
    // Bytes are only taken in IDLE, so "not ready" is exactly "busy".
    assign busy       = !ready_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_term_writer.sv
module tb_text_term_writer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic [4:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    // Bench-side RAM model with a backdoor write port for preloading.
    logic [7:0] mem [0:1023];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    text_term_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (reset_n) begin
            assert (ram_addr < 10'd960) else begin
                nerr++;
                $error("FAIL addr_range: observed %0d required < 960", ram_addr);
            end
            assert (!(ram_we && in_ready)) else begin
                nerr++;
                $error("FAIL we_in_idle: observed ram_we=1 with in_ready=1 required not both");
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    // Present a byte, hold it until taken; returns on the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            nerr++;
            $error("FAIL send_timeout: observed in_ready=0 for %0d cycles required 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Starting from the current sample (first cycle of a clear), follow the clear to IDLE.
    task automatic scan_clear(input string tag);
        int writes, bad, cyc;
        writes = 0;
        bad    = 0;
        cyc    = 0;
        while (!in_ready && cyc < 3000) begin
            cyc++;
            if (ram_we) begin
                if (ram_addr != 10'(writes) || ram_din != 8'h20) bad++;
                writes++;
            end
            if (cursor_col != 0 || cursor_row != 0) bad++;
            @(negedge clk);
        end
        cyc++;
        check({tag, "_writes"}, 32'(writes), 32'd960);
        check({tag, "_bad"}, 32'(bad), 32'd0);
        check({tag, "_ready_cycle"}, 32'(cyc), 32'd961);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt, bad;

        // T1: reset state, then power-on clear.
        repeat (3) @(negedge clk);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check_cursor("rst", 0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        scan_clear("t1");

        // T2: "AB".
        send(8'h41);
        check("t2a_we", 32'(ram_we), 32'd1);
        check("t2a_addr", 32'(ram_addr), 32'd0);
        check("t2a_din", 32'(ram_din), 32'h41);
        check("t2a_ready", 32'(in_ready), 32'd0);
        send(8'h42);
        check("t2b_addr", 32'(ram_addr), 32'd1);
        check("t2b_din", 32'(ram_din), 32'h42);
        check("t2b_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t2_ready_back", 32'(in_ready), 32'd1);
        check("t2_mem0", 32'(mem[0]), 32'h41);
        check("t2_mem1", 32'(mem[1]), 32'h42);
        check_cursor("t2", 2, 0);

        // T3: CR, then 33 printables wrapping into row 1, then CR LF.
        send(8'h0D);
        check_cursor("t3_cr", 0, 0);
        for (int k = 0; k < 33; k++) send(8'h30 + 8'(k));
        @(negedge clk);
        check("t3_mem0", 32'(mem[0]), 32'h30);
        check("t3_mem31", 32'(mem[31]), 32'h4F);
        check("t3_mem32", 32'(mem[32]), 32'h50);
        check_cursor("t3_wrap", 1, 1);
        send(8'h0D);
        send(8'h0A);
        check_cursor("t3_crlf", 0, 2);

        // T5: BS at col 0, ignored byte, BS without erase, FF clear.
        send(8'h08);
        check_cursor("t5_bs0", 0, 2);
        send(8'h07);
        check_cursor("t5_bel", 0, 2);
        check("t5_bel_ready", 32'(in_ready), 32'd1);
        check("t5_bel_we", 32'(ram_we), 32'd0);
        send(8'h0A);
        send(8'h0A);
        for (int k = 0; k < 10; k++) send(8'h61 + 8'(k));
        @(negedge clk);
        check_cursor("t5_pos", 10, 4);
        check("t5_mem128", 32'(mem[128]), 32'h61);
        send(8'h08);
        check_cursor("t5_bs", 9, 4);
        check("t5_no_erase", 32'(mem[137]), 32'h6A);
        send(8'h6B);
        @(negedge clk);
        check("t5_overwrite", 32'(mem[137]), 32'h6B);
        check_cursor("t5_back", 10, 4);
        send(8'h0C);
        scan_clear("t5_ff");
        check_cursor("t5_ff", 0, 0);
        check("t5_ff_mem137", 32'(mem[137]), 32'h20);

        // T4: scroll from (5,29) with a marker at RAM[32].
        for (int k = 0; k < 29; k++) send(8'h0A);
        check_cursor("t4_bottom", 0, 29);
        for (int k = 0; k < 5; k++) send(8'h61 + 8'(k));
        @(negedge clk);
        check_cursor("t4_pos", 5, 29);
        bd_addr = 10'd32;
        bd_data = 8'h58;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
        send(8'h0A);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_busy_cycles", 32'(cnt), 32'd1888);
        check("t4_mem0", 32'(mem[0]), 32'h58);
        check("t4_mem896", 32'(mem[896]), 32'h61);
        check("t4_mem900", 32'(mem[900]), 32'h65);
        bad = 0;
        for (int a = 928; a < 960; a++) if (mem[a] !== 8'h20) bad++;
        check("t4_bottom_blank", 32'(bad), 32'd0);
        check_cursor("t4_after", 5, 29);

        // T6: one-cycle reset in the middle of a scroll.
        send(8'h0A);
        repeat (100) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_we", 32'(ram_we), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd0);
        check("t6_addr", 32'(ram_addr), 32'd0);
        check_cursor("t6_rst", 0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        scan_clear("t6");
        check("t6_mem0", 32'(mem[0]), 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
